// File: rtl/param_shift_reg_if.sv
// rtl/param_shift_reg_if.sv - control/data bundle for the burst shift register
interface param_shift_reg_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             load;
    logic [WIDTH-1:0] in;
    logic             start;
    logic [2:0]       mode;
    logic [CNT_W-1:0] count;
    logic             ser_in;
    logic [WIDTH-1:0] out;
    logic             ser_out;
    logic             busy;
    logic             done;

    modport master (
        output load, in, start, mode, count, ser_in,
        input  out, ser_out, busy, done
    );

    modport slave (
        input  load, in, start, mode, count, ser_in,
        output out, ser_out, busy, done
    );
endinterface

// File: rtl/param_shift_reg.sv
// rtl/param_shift_reg.sv - parallel-load register with counted burst shift/rotate
module param_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    param_shift_reg_if.slave   bus
);
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = out_q;
        case (mode_q)
            3'b000:  shifted = {1'b0, out_q[WIDTH-1:1]};
            3'b001:  shifted = {out_q[WIDTH-2:0], 1'b0};
            3'b010:  shifted = {out_q[WIDTH-1], out_q[WIDTH-1:1]};
            3'b011:  shifted = {out_q[0], out_q[WIDTH-1:1]};
            3'b100:  shifted = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
            3'b101:  shifted = {bus.ser_in, out_q[WIDTH-1:1]};
            3'b110:  shifted = {out_q[WIDTH-2:0], bus.ser_in};
            default: shifted = out_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    out_d = bus.in;
                end else if (bus.start) begin
                    if (bus.count != '0) begin
                        mode_d  = bus.mode;
                        cnt_d   = bus.count;
                        state_d = SHIFT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                out_d = shifted;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            mode_q  <= 3'b000;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Left-type modes expose the MSB; everything else (incl. idle and reserved) the LSB.
    always_comb begin
        bus.ser_out = out_q[0];
        if (state_q == SHIFT && (mode_q == 3'b001 || mode_q == 3'b100 || mode_q == 3'b110))
            bus.ser_out = out_q[WIDTH-1];
    end

    assign bus.out  = out_q;
    assign bus.busy = (state_q == SHIFT);
    assign bus.done = done_q;
endmodule

// File: tb/tb_param_shift_reg.sv
// tb/tb_param_shift_reg.sv - directed bench with reference model for param_shift_reg
module tb_param_shift_reg;
    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    param_shift_reg_if #(.WIDTH(W), .CNT_W(CW)) bus();
    param_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] m_out;
    int           m_left;
    int           m_mode;
    bit           m_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] apply(input int md, input logic [W-1:0] v, input logic s);
        case (md)
            0: return v >> 1;
            1: return v << 1;
            2: return W'($signed(v) >>> 1);
            3: return (v >> 1) | (W'(v[0]) << (W-1));
            4: return (v << 1) | W'(v[W-1]);
            5: return (v >> 1) | (W'(s) << (W-1));
            6: return (v << 1) | W'(s);
            default: return v;
        endcase
    endfunction

    // Reference: a burst is simply "remaining shifts"; busy whenever any remain.
    always @(posedge clk) begin
        bit dn;
        if (!rst) begin
            m_out = '0; m_left = 0; m_mode = 0; m_done = 1'b0;
        end else begin
            dn = 1'b0;
            if (m_left == 0) begin
                if (bus.load) m_out = bus.in;
                else if (bus.start) begin
                    if (bus.count == 0) dn = 1'b1;
                    else begin
                        m_left = int'(bus.count);
                        m_mode = int'(bus.mode);
                    end
                end
            end else begin
                m_out  = apply(m_mode, m_out, bus.ser_in);
                m_left = m_left - 1;
                if (m_left == 0) dn = 1'b1;
            end
            m_done = dn;
        end
    end

    always @(negedge clk) begin
        logic exp_so;
        if (chk_en) begin
            exp_so = m_out[0];
            if (m_left != 0 && (m_mode == 1 || m_mode == 4 || m_mode == 6)) exp_so = m_out[W-1];
            check("out", 32'(bus.out), 32'(m_out));
            check("busy", 32'(bus.busy), 32'(m_left != 0));
            check("done", 32'(bus.done), 32'(m_done));
            check("ser_out", 32'(bus.ser_out), 32'(exp_so));
            if (bus.busy && bus.done) check("busy_done_overlap", 32'(1), 32'(0));
        end
    end

    task automatic do_load(input logic [W-1:0] v);
        bus.load = 1'b1; bus.in = v;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] md, input logic [CW-1:0] c);
        bus.start = 1'b1; bus.mode = md; bus.count = c;
        @(negedge clk);
        bus.start = 1'b0; bus.mode = 3'b111; bus.count = '1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", 32'(bus.done), 32'(1));
    endtask

    initial begin
        int busy_cycles;
        rst = 1'b0;
        bus.load = 1'b0; bus.in = '0; bus.start = 1'b0;
        bus.mode = 3'b000; bus.count = '0; bus.ser_in = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_out", 32'(bus.out), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_ser_out", 32'(bus.ser_out), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // logical right with ser_out sequence
        do_load(8'hB5);
        do_start(3'b000, 4'd3);
        check("r_so0", 32'(bus.ser_out), 32'h1);
        @(negedge clk);
        check("r_so1", 32'(bus.ser_out), 32'h0);
        @(negedge clk);
        check("r_so2", 32'(bus.ser_out), 32'h1);
        check("r_busy", 32'(bus.busy), 32'h1);
        @(negedge clk);
        check("r_out", 32'(bus.out), 32'h16);
        check("r_done", 32'(bus.done), 32'h1);
        check("r_idle", 32'(bus.busy), 32'h0);
        @(negedge clk);
        check("r_done_once", 32'(bus.done), 32'h0);

        // arithmetic vs logical
        do_load(8'h90); do_start(3'b010, 4'd2); wait_done();
        check("asr_out", 32'(bus.out), 32'hE4);
        do_load(8'h90); do_start(3'b000, 4'd2); wait_done();
        check("lsr_out", 32'(bus.out), 32'h24);

        // rotate wrap
        do_load(8'h81); do_start(3'b100, 4'd8); wait_done();
        check("rol8_out", 32'(bus.out), 32'h81);
        do_start(3'b011, 4'd1); wait_done();
        check("ror1_out", 32'(bus.out), 32'hC0);

        // serial left, then zero-count start
        do_load(8'h00);
        do_start(3'b110, 4'd4);
        bus.ser_in = 1'b1; @(negedge clk);
        bus.ser_in = 1'b0; @(negedge clk);
        bus.ser_in = 1'b1; @(negedge clk);
        bus.ser_in = 1'b1; @(negedge clk);
        bus.ser_in = 1'b0;
        check("ser_out_val", 32'(bus.out), 32'h0B);
        check("ser_done", 32'(bus.done), 32'h1);
        @(negedge clk);
        do_start(3'b000, 4'd0);
        check("zc_done", 32'(bus.done), 32'h1);
        check("zc_busy", 32'(bus.busy), 32'h0);
        check("zc_out", 32'(bus.out), 32'h0B);

        // serial right and reserved mode
        do_load(8'h0F);
        bus.ser_in = 1'b1;
        do_start(3'b101, 4'd2); wait_done();
        bus.ser_in = 1'b0;
        check("srr_out", 32'(bus.out), 32'hC3);
        do_start(3'b111, 4'd5); wait_done();
        check("rsv_out", 32'(bus.out), 32'hC3);

        // collisions
        bus.load = 1'b1; bus.in = 8'hFF; bus.start = 1'b1; bus.mode = 3'b000; bus.count = 4'd3;
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b0;
        check("col_out", 32'(bus.out), 32'hFF);
        check("col_busy", 32'(bus.busy), 32'h0);
        do_start(3'b000, 4'd4);
        bus.load = 1'b1; bus.in = 8'h00; bus.start = 1'b1; bus.mode = 3'b001; bus.count = 4'd2;
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b0;
        wait_done();
        check("col_burst_out", 32'(bus.out), 32'h0F);
        do_start(3'b011, 4'd1);
        check("col_done_start", 32'(bus.busy), 32'h1);
        wait_done();
        check("col_ror_out", 32'(bus.out), 32'h87);

        // max count, 15 shifts
        do_load(8'hFF);
        do_start(3'b000, 4'd15);
        busy_cycles = 0;
        while (bus.busy && busy_cycles < 40) begin
            busy_cycles++;
            @(negedge clk);
        end
        check("max_cycles", 32'(busy_cycles), 32'd15);
        check("max_out", 32'(bus.out), 32'h00);
        check("max_done", 32'(bus.done), 32'h1);

        // reset mid-burst
        do_load(8'h03);
        do_start(3'b001, 4'd10);
        repeat (4) @(negedge clk);
        check("mid_out", 32'(bus.out), 32'h30);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("abort_out", 32'(bus.out), 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        @(negedge clk);
        check("abort_no_done", 32'(bus.done), 32'h0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/param_shift_reg.md
PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter CNT_W, default 4, shift-count width (max burst 2^CNT_W-1 shifts).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have port load  input  1  parallel-load request.
REQ-006 SHALL have port in  input  WIDTH  parallel-load data.
REQ-007 SHALL have port start  input  1  burst-shift request.
REQ-008 SHALL have port mode  input  3  shift operation, sampled with start.
REQ-009 SHALL have port count  input  CNT_W  number of single-bit shifts in the burst, sampled with start.
REQ-010 SHALL have port ser_in  input  1  serial input bit for modes 101/110.
REQ-011 SHALL have port out  output  WIDTH  register contents.
REQ-012 SHALL have port ser_out  output  1  bit being shifted out.
REQ-013 SHALL have port busy  output  1  high while a burst is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse on burst completion.

Function
REQ-015 SHALL implement a two-state FSM, IDLE and SHIFT; in IDLE busy=0, in SHIFT busy=1.
REQ-016 In IDLE, load=1 SHALL set out<=in at the edge; load has priority over start (start ignored that cycle).
REQ-017 In IDLE, start=1, load=0, count>0: SHALL latch mode and count, enter SHIFT; out unchanged at this edge.
REQ-018 In IDLE, start=1, load=0, count=0: SHALL stay IDLE, leave out unchanged, pulse done for one cycle.
REQ-019 In SHIFT, each edge SHALL apply exactly one single-bit shift per the latched mode and decrement the remaining count.
REQ-020 Latency: start sampled at edge k with count=N -> shifts at edges k+1..k+N; after edge k+N state=IDLE, busy=0, done=1 for exactly one cycle.
REQ-021 Mode 000 logical right (0 into MSB); 001 logical left (0 into LSB); 010 arithmetic right (MSB replicated).
REQ-022 Mode 011 rotate right (LSB into MSB); 100 rotate left (MSB into LSB).
REQ-023 Mode 101 serial right (ser_in into MSB); 110 serial left (ser_in into LSB); ser_in sampled at each shift edge.
REQ-024 Mode 111 reserved: burst SHALL run for full count with out held unchanged, then done as normal.
REQ-025 ser_out SHALL equal out[0] for right-type modes (000,010,011,101) and out[WIDTH-1] for left-type modes (001,100,110), using the latched mode; in IDLE and for mode 111, ser_out = out[0].
REQ-026 load and start asserted while busy=1 SHALL be ignored; mode/count changes during SHIFT SHALL have no effect.
REQ-027 start asserted in the same cycle done=1 (state IDLE) SHALL be accepted per REQ-017/018.
REQ-028 done SHALL never be high in the same cycle as busy.
REQ-029 Count arithmetic SHALL be unsigned CNT_W bits; count=2^CNT_W-1 SHALL perform that many shifts, no wrap.

Reset
REQ-030 rst=0 at an edge SHALL force out=0, state=IDLE, busy=0, done=0, latched count=0, overriding load/start.
REQ-031 Reset during SHIFT SHALL abort the burst with no done pulse; operation resumes only after rst=1.
REQ-032 ser_out SHALL be 0 after reset (out[0]=0).

Verification
REQ-033 Load/right: rst, load in=8'hB5, start mode=000 count=3 -> busy 3 cycles, out=8'h16, done pulse, ser_out sequence 1,0,1 before each shift.
REQ-034 Arithmetic vs logical: load 8'h90, mode=010 count=2 -> out=8'hE4; reload 8'h90, mode=000 count=2 -> out=8'h24.
REQ-035 Rotate wrap: load 8'h81, mode=100 count=8 -> out=8'h81 after 8 shifts; mode=011 count=1 -> out=8'hC0.
REQ-036 Serial: load 8'h00, mode=110 count=4, ser_in=1,0,1,1 -> out=8'h0B; count=0 start -> done next cycle, out unchanged.
REQ-037 Collisions: load 8'hFF with start same cycle -> out=8'hFF, no burst; load/start during burst ignored; start on done cycle accepted.
REQ-038 Reset mid-burst: mode=001 count=10, rst=0 after 4 shifts -> out=0, busy=0, no done pulse.
